mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter feeding a 4-way select into one registered output stage,
// with optional burst hold so one requester can keep the grant for BURST transfers.
module mux4_rr_arbiter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req_valid,
   input  logic [WIDTH-1:0] req_data0,
   input  logic [WIDTH-1:0] req_data1,
   input  logic [WIDTH-1:0] req_data2,
   input  logic [WIDTH-1:0] req_data3,
   output logic [3:0]       req_ready,
   output logic [1:0]       sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_src,
   input  logic             out_ready
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [1:0]         owner_q, owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic [1:0]         out_src_q, out_src_d;

   logic               load_en;
   logic               hold;
   logic               grant;
   logic [1:0]         winner;
   logic [1:0]         scan_idx;
   logic [7:0]         dbl_req;
   logic [3:0]         rot_req;
   logic [WIDTH-1:0]   mux_data;

   // Rotate requests so bit 0 is the pointer position, then take the first set bit.
   always_comb begin
      dbl_req  = {req_valid, req_valid};
      rot_req  = 4'(dbl_req >> ptr_q);
      scan_idx = ptr_q;
      if (rot_req[0])      scan_idx = ptr_q;
      else if (rot_req[1]) scan_idx = ptr_q + 2'd1;
      else if (rot_req[2]) scan_idx = ptr_q + 2'd2;
      else if (rot_req[3]) scan_idx = ptr_q + 2'd3;
   end

   always_comb begin
      load_en   = !out_valid_q || out_ready;
      hold      = (state_q == LOCKED) && req_valid[owner_q] && (cnt_q < CNT_W'(BURST - 1));
      grant     = !rst && load_en && (|req_valid);
      winner    = hold ? owner_q : scan_idx;
      req_ready = grant ? (4'b0001 << winner) : 4'b0000;
      sel       = rst ? 2'd0 : (grant ? winner : owner_q);
   end

   // The shared mux4 datapath, steered by sel.
   always_comb begin
      case (sel)
         2'd0:    mux_data = req_data0;
         2'd1:    mux_data = req_data1;
         2'd2:    mux_data = req_data2;
         default: mux_data = req_data3;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (grant) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_data;
         out_src_d   = winner;
         state_d     = LOCKED;
         if (hold) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            // Fresh grant, including an expired owner winning the scan again.
            owner_d = winner;
            cnt_d   = '0;
            ptr_d   = winner + 2'd1;
         end
      end else if (load_en) begin
         out_valid_d = 1'b0;
         if (!req_valid[owner_q]) begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= 2'd0;
         owner_q     <= 2'd0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= 2'd0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench: three arbiters (BURST=1,4,2) share one stimulus stream and are
// checked against a grant-history reference model.
module tb_mux4_rr_arbiter;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_valid;
   logic [7:0] d0, d1, d2, d3;
   logic       out_ready;

   logic [3:0] rr_w  [NI];
   logic [1:0] sel_w [NI];
   logic       ov_w  [NI];
   logic [7:0] od_w  [NI];
   logic [1:0] os_w  [NI];

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mux4_rr_arbiter #(
         .WIDTH(8),
         .BURST((g == 0) ? 1 : ((g == 1) ? 4 : 2))
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid),
         .req_data0 (d0),
         .req_data1 (d1),
         .req_data2 (d2),
         .req_data3 (d3),
         .req_ready (rr_w[g]),
         .sel       (sel_w[g]),
         .out_valid (ov_w[g]),
         .out_data  (od_w[g]),
         .out_src   (os_w[g]),
         .out_ready (out_ready)
      );
   end

   // Reference model: owner (-1 when none), length of its current run, scan start.
   int   m_owner [NI];
   int   m_last  [NI];
   int   m_run   [NI];
   int   m_ptr   [NI];
   bit   m_ov    [NI];
   logic [9:0] q0[$], q1[$], q2[$];

   function automatic int burst_of(input int i);
      if (i == 0) return 1;
      if (i == 1) return 4;
      return 2;
   endfunction

   function automatic logic [7:0] data_of(input int idx);
      case (idx)
         0:       return d0;
         1:       return d1;
         2:       return d2;
         default: return d3;
      endcase
   endfunction

   function automatic int m_winner(input int i);
      if (rst) return -1;
      if (m_ov[i] && !out_ready) return -1;
      if (req_valid == 4'b0000) return -1;
      if (m_owner[i] >= 0 && req_valid[m_owner[i]] && m_run[i] < burst_of(i)) return m_owner[i];
      for (int k = 0; k < 4; k++) begin
         if (req_valid[(m_ptr[i] + k) % 4]) return (m_ptr[i] + k) % 4;
      end
      return -1;
   endfunction

   function automatic int sb_size(input int i);
      if (i == 0) return q0.size();
      if (i == 1) return q1.size();
      return q2.size();
   endfunction

   function automatic logic [9:0] sb_peek(input int i);
      if (i == 0) return q0[0];
      if (i == 1) return q1[0];
      return q2[0];
   endfunction

   task automatic sb_push(input int i, input logic [9:0] v);
      if (i == 0) q0.push_back(v);
      else if (i == 1) q1.push_back(v);
      else q2.push_back(v);
   endtask

   task automatic sb_pop(input int i);
      if (i == 0) void'(q0.pop_front());
      else if (i == 1) void'(q1.pop_front());
      else void'(q2.pop_front());
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_owner[i] = -1;
         m_last[i]  = 0;
         m_run[i]   = 0;
         m_ptr[i]   = 0;
         m_ov[i]    = 1'b0;
      end
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s inst%0d(BURST=%0d) got %0h expected %0h at %0t",
                    nm, i, burst_of(i), act, exp, $time);
   endtask

   // Model advance on each accepted edge; expected words go to the scoreboard.
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NI; i++) begin
            int  w;
            bit  held;
            w = m_winner(i);
            if (w >= 0) begin
               held = (w == m_owner[i]) && (m_run[i] < burst_of(i));
               sb_push(i, {2'(w), data_of(w)});
               if (held) begin
                  m_run[i]++;
               end else begin
                  m_owner[i] = w;
                  m_last[i]  = w;
                  m_run[i]   = 1;
                  m_ptr[i]   = (w + 1) % 4;
               end
               m_ov[i] = 1'b1;
            end else if (!m_ov[i] || out_ready) begin
               m_ov[i] = 1'b0;
               if (m_owner[i] >= 0 && !req_valid[m_owner[i]]) m_owner[i] = -1;
            end
         end
      end
   end

   // Monitor: combinational grant checks and scoreboard compare of the output register.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         int w;
         w = m_winner(i);
         chk("req_ready", i, 32'(rr_w[i]), (w >= 0) ? 32'(4'b0001 << w) : 32'd0);
         chk("sel", i, 32'(sel_w[i]), (w >= 0) ? 32'(w) : 32'(m_last[i]));
         chk("out_valid", i, 32'(ov_w[i]), 32'(m_ov[i]));
         if (ov_w[i] === 1'b1) begin
            if (sb_size(i) == 0) begin
               chk("sb_underflow", i, 32'd1, 32'd0);
            end else begin
               chk("out_word", i, 32'({os_w[i], od_w[i]}), 32'(sb_peek(i)));
               if (out_ready) sb_pop(i);
            end
         end
      end
   end

   task automatic step(input logic [3:0] v, input logic ordy);
      @(posedge clk);
      #1;
      req_valid = v;
      out_ready = ordy;
   endtask

   task automatic check_reset_outputs();
      for (int i = 0; i < NI; i++) begin
         chk("rst_out_valid", i, 32'(ov_w[i]), 32'd0);
         chk("rst_req_ready", i, 32'(rr_w[i]), 32'd0);
         chk("rst_sel", i, 32'(sel_w[i]), 32'd0);
      end
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'b1111;
      out_ready = 1'b1;
      d0 = 8'h10; d1 = 8'h21; d2 = 8'h32; d3 = 8'h43;
      model_reset();
      #1;
      check_reset_outputs();
      for (int i = 0; i < NI; i++) begin
         chk("rst_out_data", i, 32'(od_w[i]), 32'd0);
         chk("rst_out_src", i, 32'(os_w[i]), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // All four requesting, full throughput.
      repeat (12) step(4'b1111, 1'b1);
      // Backpressure for three cycles, then resume.
      repeat (3) step(4'b1111, 1'b0);
      repeat (3) step(4'b1111, 1'b1);
      // Owner drop: only req 2, then reqs 0 and 3.
      repeat (2) step(4'b0100, 1'b1);
      repeat (3) step(4'b1001, 1'b1);
      // Sole requester through burst expiry.
      repeat (5) step(4'b0010, 1'b1);
      repeat (2) step(4'b0000, 1'b1);

      // Async reset pulse between edges while streaming.
      repeat (4) step(4'b1111, 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check_reset_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) step(4'b1111, 1'b1);

      // Randomized traffic with random data and backpressure.
      for (int n = 0; n < 400; n++) begin
         @(posedge clk);
         #1;
         req_valid = 4'($urandom);
         out_ready = ($urandom % 4) != 0;
         d0 = 8'($urandom); d1 = 8'($urandom);
         d2 = 8'($urandom); d3 = 8'($urandom);
      end

      // Drain and confirm nothing is left outstanding.
      repeat (3) step(4'b0000, 1'b1);
      @(negedge clk);
      #1;
      for (int i = 0; i < NI; i++) chk("sb_empty", i, 32'(sb_size(i)), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
